cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Arbiter that shares the single 256-bit line-granular memory port between the instruction cache (read-only) and the data cache (read/write). It sits between the two caches' downward-facing ports and the memory/burst adapter. Each winning request is latched and forwarded as one transaction, and the memory response is routed back to the requester. Only one transaction is outstanding at a time.

## Interface
- No parameters. Widths are fixed: address 32, line 256.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_addr  in  32  I-cache line address, bits [4:0] = 0
- i_read  in  1  I-cache read request, held until i_resp
- i_rdata  out  256  line returned to the I-cache
- i_resp  out  1  one-cycle completion pulse to the I-cache
- d_addr  in  32  D-cache line address
- d_read  in  1  D-cache read request, held until d_resp
- d_write  in  1  D-cache write-back request, held until d_resp
- d_wdata  in  256  D-cache write-back line
- d_rdata  out  256  line returned to the D-cache
- d_resp  out  1  one-cycle completion pulse to the D-cache
- mem_addr  out  32  memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  256  memory write data
- mem_rdata  in  256  memory read data
- mem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE
  - Sample requests. Pending: I = i_read; D = d_read | d_write.
  - One pending → grant it.
  - Both pending → resolve by the priority rule (see Configuration).
  - On grant, latch the address. For D, also latch the wdata and op; write wins if d_read and d_write are both high (protocol violation, tolerated).
  - Move to SERVE_I or SERVE_D.
- SERVE_I / SERVE_D
  - Drive mem_addr from the latched address. Drive mem_read (I, or D read) or mem_write (D write), plus latched mem_wdata.
  - Hold all of these stable until mem_resp.
  - On mem_resp: assert the granted side's resp in the same cycle, with its rdata = mem_rdata, and move to RECOVER.
- RECOVER
  - One dead cycle: mem strobes low, no requests sampled. This lets the served cache drop or renew its request, so a stale held request is never re-granted. Then go to IDLE.
- The non-granted cache always sees resp = 0. Its rdata is don't-care; drive it with mem_rdata (the same bus fans out to both).
- Requests deasserted mid-transaction are ignored. The latched transaction completes, and resp is still pulsed.
- mem_resp outside SERVE_* is ignored.

## Timing
- Reset: state = IDLE. mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, i_resp = d_resp = 0, latched registers = 0. The priority pointer resets to favour D.
- Reset mid-transaction abandons it: next cycle is IDLE with outputs as above. Memory must also be reset.
- Request high in cycle N (arbiter in IDLE) → mem strobe high from cycle N+1.
- mem_resp in cycle M → x_resp in cycle M, combinational from mem_resp and state. Strobes drop at M+1 (RECOVER). The next grant is decided no earlier than cycle M+2 (IDLE); its mem strobe rises no earlier than M+3.
- Minimum turnaround: 4 cycles per transaction when memory responds in the cycle after the strobe rises.
- mem_* outputs are driven from registers and state only, with no combinational path from i_*/d_*.
- The strobe is held high continuously through wait states. At most one of mem_read or mem_write is high at any time.

## Configuration
- CACHE_ARB_RR_EN
  - Defined: round-robin. A 1-bit pointer names the preferred side when both are pending. After each completed grant, the pointer flips to the other side.
  - Undefined: fixed priority, D always beats I. This minimises load/store stall; I can starve only under continuous D traffic.
- Single-requester behaviour is identical in both builds.

## Test plan
- Lone I read: i_addr=0x0000_1240, i_read=1; memory returns 0xAA..AA after 3 wait cycles → mem_read=1, mem_addr=0x1240 held for 4 cycles; i_resp=1 with i_rdata=0xAA..AA in one cycle; d_resp stays 0.
- Lone D write-back: d_addr=0x8000_0020, d_write=1, d_wdata=0x5555..; mem_resp after 2 cycles → mem_write=1, mem_wdata=0x5555.., mem_read=0 throughout; d_resp pulses once.
- Simultaneous I read + D read in the same IDLE cycle → D served first in both builds (reset pointer). Then I is served, with its first mem strobe 3 cycles after d_resp.
- Back-to-back contention, 4 rounds with both always pending:
  - Without the macro: grant order D,D,D,D.
  - With CACHE_ARB_RR_EN: D,I,D,I.
- rst asserted while in SERVE_D waiting for mem_resp → next cycle IDLE, all mem strobes 0, no d_resp. A subsequent request is served normally.
- d_read and d_write both high with d_addr=0x40 → treated as write: mem_write=1, mem_read=0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Line-granular memory request bus shared by the cache-side ports and the
// memory-side port of cache_mem_arbiter. One request is presented on
// addr/read/write/wdata and held until the one-cycle resp pulse, which
// qualifies rdata.
//
// Signals:
//   addr   [31:0]   line address, bits [4:0] = 0
//   read            read request / strobe
//   write           write request / strobe
//   wdata  [255:0]  write line
//   rdata  [255:0]  returned line, valid with resp
//   resp            one-cycle completion pulse
//
// Modports:
//   master : issues requests (a cache, or the arbiter towards memory)
//   slave  : services requests (the arbiter towards a cache, or memory)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;
    logic [31:0]  addr;
    logic         read;
    logic         write;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         resp;

    modport master (
        output addr, read, write, wdata,
        input  rdata, resp
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one 256-bit line memory port between the instruction cache
// (read-only) and the data cache (read/write-back). A winning request is
// latched in IDLE and forwarded as a single memory transaction; the memory
// response is routed back to the requester in the same cycle. Only one
// transaction is outstanding. A one-cycle RECOVER state after each
// completion gives the served cache time to drop or renew its request, so a
// stale held request is never granted twice.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   icache   slave  : I-cache line reads (write/wdata are not used)
//   dcache   slave  : D-cache line reads and write-backs
//   mem      master : memory / burst adapter port
//
// Configuration macro:
//   CACHE_ARB_RR_EN  defined   -> round-robin between I and D under contention
//                    undefined -> fixed priority, D always beats I
//   Single-requester behaviour is identical in both builds.
//
// The mem strobes, address and write data come only from state and latched
// registers; icache/dcache resp is combinational from mem.resp and state.
// -----------------------------------------------------------------------------
module cache_mem_arbiter (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  icache,
    cache_mem_arbiter_if.slave  dcache,
    cache_mem_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Transaction latched at grant time.
    logic [31:0]  lat_addr;
    logic [255:0] lat_wdata;
    logic         lat_write;

    logic i_pend;
    logic d_pend;
    logic prefer_d;
    logic grant_i;
    logic grant_d;

    logic mem_read_c;
    logic mem_write_c;
    logic i_resp_c;
    logic d_resp_c;

    assign i_pend = icache.read;
    assign d_pend = dcache.read | dcache.write;

`ifdef CACHE_ARB_RR_EN
    // Preference bit: 1 = D wins a tie. After every completed transaction
    // the preference moves to the side that was not just served. A reset
    // that abandons a transaction leaves it at its reset value.
    logic rr_prefer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prefer_d <= 1'b1;
        end else if (mem.resp) begin
            if (state == SERVE_I) begin
                rr_prefer_d <= 1'b1;
            end else if (state == SERVE_D) begin
                rr_prefer_d <= 1'b0;
            end
        end
    end

    assign prefer_d = rr_prefer_d;
`else
    assign prefer_d = 1'b1;
`endif

    // Grants are only acted on in IDLE; outside IDLE these are ignored.
    assign grant_d = d_pend & (~i_pend | prefer_d);
    assign grant_i = i_pend & ~grant_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default on entry,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem.resp) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transaction latch: captured once, in the IDLE cycle that grants.
    // Write wins when the D-cache raises read and write together.
    // -------------------------------------------------------------------------
    // NOTE: the wide data register is reset on purpose, so mem.wdata reads
    // zero after reset instead of leftover content from an abandoned
    // write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                lat_addr  <= dcache.addr;
                lat_wdata <= dcache.wdata;
                lat_write <= dcache.write;
            end else if (grant_i) begin
                lat_addr  <= icache.addr;
                lat_wdata <= '0;
                lat_write <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: strobes from state and the latched op only; resp pulses
    // follow mem.resp only in the matching SERVE state, so a stray mem.resp
    // in IDLE or RECOVER is dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        i_resp_c    = 1'b0;
        d_resp_c    = 1'b0;
        case (state)
            SERVE_I: begin
                mem_read_c = 1'b1;
                i_resp_c   = mem.resp;
            end
            SERVE_D: begin
                mem_read_c  = ~lat_write;
                mem_write_c = lat_write;
                d_resp_c    = mem.resp;
            end
            default: begin
            end
        endcase
    end

    assign mem.addr  = lat_addr;
    assign mem.wdata = lat_wdata;
    assign mem.read  = mem_read_c;
    assign mem.write = mem_write_c;

    // The memory read bus fans out to both caches; resp qualifies it.
    assign icache.rdata = mem.rdata;
    assign dcache.rdata = mem.rdata;
    assign icache.resp  = i_resp_c;
    assign dcache.resp  = d_resp_c;

endmodule
